mux4_sel_reg: RTL and testbench

Parameterised 4-to-1 word multiplexer with a registered output stage, for datapath steering where a clean, glitch-free, clock-aligned selected word is required. Four WIDTH-bit inputs are selected by a 2-bit select. A combinational path is also exposed for same-cycle consumers. The registered result carries a one-cycle valid strobe.

---
 rtl/mux4_sel_reg.sv | 66 ++++++
 tb/tb_mux4_sel_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_sel_reg.sv
// 4-to-1 word multiplexer with an unregistered select path and a registered,
// enable-gated capture stage that raises a one-cycle valid strobe per capture.
module mux4_sel_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [1:0]       sel,
    input  logic             en,
    output logic [WIDTH-1:0] ou1_comb,
    output logic [WIDTH-1:0] ou1,
    output logic [1:0]       sel_q,
    output logic             valid
);

    logic [WIDTH-1:0] mux_word;
    logic [WIDTH-1:0] ou1_d,   ou1_q;
    logic [1:0]       sel_d,   sel_cap_q;
    logic             valid_d, valid_q;

    // Fully decoded select; the default keeps the block latch-free.
    always_comb begin
        mux_word = in1;
        case (sel)
            2'b00:   mux_word = in1;
            2'b01:   mux_word = in2;
            2'b10:   mux_word = in3;
            2'b11:   mux_word = in4;
            default: mux_word = in1;
        endcase
    end

    always_comb begin
        ou1_d   = ou1_q;
        sel_d   = sel_cap_q;
        valid_d = 1'b0;
        if (en) begin
            ou1_d   = mux_word;
            sel_d   = sel;
            valid_d = 1'b1;
        end
    end

    // Reset is sampled on the clock edge and overrides any pending capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ou1_q     <= '0;
            sel_cap_q <= 2'b00;
            valid_q   <= 1'b0;
        end else begin
            ou1_q     <= ou1_d;
            sel_cap_q <= sel_d;
            valid_q   <= valid_d;
        end
    end

    assign ou1_comb = mux_word;
    assign ou1      = ou1_q;
    assign sel_q    = sel_cap_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_mux4_sel_reg.sv
// Directed bench for mux4_sel_reg: a WIDTH=4 instance for the main scenarios
// and a WIDTH=8 instance for full-word selection.
module tb_mux4_sel_reg;

    logic       clk;
    logic       rst_n;
    logic [3:0] in1, in2, in3, in4;
    logic [1:0] sel;
    logic       en;
    logic [3:0] ou1_comb, ou1;
    logic [1:0] sel_q;
    logic       valid;

    logic [7:0] w_in1, w_in2, w_in3, w_in4;
    logic [1:0] w_sel;
    logic       w_en;
    logic [7:0] w_ou1_comb, w_ou1;
    logic [1:0] w_sel_q;
    logic       w_valid;

    int errors = 0;
    int checks = 0;

    mux4_sel_reg #(.WIDTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .sel(sel), .en(en),
        .ou1_comb(ou1_comb), .ou1(ou1), .sel_q(sel_q), .valid(valid)
    );

    mux4_sel_reg #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in1(w_in1), .in2(w_in2), .in3(w_in3), .in4(w_in4),
        .sel(w_sel), .en(w_en),
        .ou1_comb(w_ou1_comb), .ou1(w_ou1), .sel_q(w_sel_q), .valid(w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 2'b00;
        in1 = 4'h1; in2 = 4'h2; in3 = 4'h3; in4 = 4'h4;
        w_en = 1'b0; w_sel = 2'b00;
        w_in1 = 8'hA5; w_in2 = 8'h5A; w_in3 = 8'hFF; w_in4 = 8'h00;
        tick();
        tick();
        checks++;
        if (ou1 !== 4'h0) begin errors++; $display("FAIL reset_ou1: got %h expected %h", ou1, 4'h0); end
        checks++;
        if (sel_q !== 2'b00) begin errors++; $display("FAIL reset_sel_q: got %b expected %b", sel_q, 2'b00); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected %b", valid, 1'b0); end
        checks++;
        if (w_ou1 !== 8'h00) begin errors++; $display("FAIL reset_w_ou1: got %h expected %h", w_ou1, 8'h00); end
        rst_n = 1'b1;
    endtask

    task automatic test_comb_sweep();
        logic [3:0] exp_c [4];
        exp_c[0] = 4'b0001; exp_c[1] = 4'b0010; exp_c[2] = 4'b0011; exp_c[3] = 4'b0100;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            checks++;
            if (ou1_comb !== exp_c[i]) begin
                errors++; $display("FAIL comb_sel%0d: got %b expected %b", i, ou1_comb, exp_c[i]);
            end
            tick();
            tick();
            checks++;
            if (ou1 !== 4'h0 || valid !== 1'b0) begin
                errors++; $display("FAIL comb_hold%0d: got ou1=%b valid=%b expected ou1=0000 valid=0", i, ou1, valid);
            end
        end
    endtask

    task automatic test_reset_release();
        rst_n = 1'b0;
        en    = 1'b1;
        sel   = 2'b10;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ou1 !== 4'h0 || sel_q !== 2'b00 || valid !== 1'b0) begin
                errors++; $display("FAIL rst_hold%0d: got ou1=%b sel_q=%b valid=%b expected 0000/00/0", i, ou1, sel_q, valid);
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (ou1 !== 4'b0011 || sel_q !== 2'b10 || valid !== 1'b1) begin
            errors++; $display("FAIL rst_release: got ou1=%b sel_q=%b valid=%b expected 0011/10/1", ou1, sel_q, valid);
        end
        // Reset asserted between edges must not disturb the registers.
        en = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (ou1 !== 4'b0011 || valid !== 1'b1) begin
            errors++; $display("FAIL rst_async: got ou1=%b valid=%b expected 0011/1", ou1, valid);
        end
        tick();
        checks++;
        if (ou1 !== 4'h0 || valid !== 1'b0) begin
            errors++; $display("FAIL rst_edge: got ou1=%b valid=%b expected 0000/0", ou1, valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_b [4];
        exp_b[0] = 4'b0001; exp_b[1] = 4'b0010; exp_b[2] = 4'b0011; exp_b[3] = 4'b0100;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            checks++;
            if (ou1 !== exp_b[i] || sel_q !== 2'(i) || valid !== 1'b1) begin
                errors++; $display("FAIL b2b_%0d: got ou1=%b sel_q=%b valid=%b expected %b/%0d/1", i, ou1, sel_q, valid, exp_b[i], i);
            end
        end
        en = 1'b0;
        sel = 2'b00;
        tick();
        checks++;
        if (ou1 !== 4'b0100 || valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drop: got ou1=%b valid=%b expected 0100/0", ou1, valid);
        end
    endtask

    task automatic test_hold();
        en  = 1'b1;
        sel = 2'b11;
        tick();
        checks++;
        if (ou1 !== 4'b0100 || sel_q !== 2'b11) begin
            errors++; $display("FAIL hold_cap: got ou1=%b sel_q=%b expected 0100/11", ou1, sel_q);
        end
        en  = 1'b0;
        in4 = 4'hF;
        sel = 2'b00;
        #1;
        checks++;
        if (ou1_comb !== 4'b0001) begin
            errors++; $display("FAIL hold_comb: got %b expected %b", ou1_comb, 4'b0001);
        end
        tick();
        tick();
        checks++;
        if (ou1 !== 4'b0100 || sel_q !== 2'b11 || valid !== 1'b0) begin
            errors++; $display("FAIL hold_regs: got ou1=%b sel_q=%b valid=%b expected 0100/11/0", ou1, sel_q, valid);
        end
        in4 = 4'h4;
    endtask

    task automatic test_reset_vs_en();
        en    = 1'b1;
        sel   = 2'b01;
        rst_n = 1'b0;
        tick();
        checks++;
        if (ou1 !== 4'h0 || sel_q !== 2'b00 || valid !== 1'b0) begin
            errors++; $display("FAIL rst_wins: got ou1=%b sel_q=%b valid=%b expected 0000/00/0", ou1, sel_q, valid);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (ou1 !== 4'b0010 || sel_q !== 2'b01 || valid !== 1'b1) begin
            errors++; $display("FAIL rst_after: got ou1=%b sel_q=%b valid=%b expected 0010/01/1", ou1, sel_q, valid);
        end
        // Inputs change right after the edge: the pre-edge word stays captured.
        sel = 2'b11;
        in2 = 4'h9;
        en  = 1'b0;
        #1;
        checks++;
        if (ou1 !== 4'b0010) begin
            errors++; $display("FAIL setup_sample: got %b expected %b", ou1, 4'b0010);
        end
        in2 = 4'h2;
    endtask

    task automatic test_wide();
        logic [7:0] exp_w [4];
        exp_w[0] = 8'hA5; exp_w[1] = 8'h5A; exp_w[2] = 8'hFF; exp_w[3] = 8'h00;
        w_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_sel = 2'(i);
            #1;
            checks++;
            if (w_ou1_comb !== exp_w[i]) begin
                errors++; $display("FAIL wide_comb%0d: got %h expected %h", i, w_ou1_comb, exp_w[i]);
            end
            tick();
            checks++;
            if (w_ou1 !== exp_w[i] || w_sel_q !== 2'(i) || w_valid !== 1'b1) begin
                errors++; $display("FAIL wide_cap%0d: got ou1=%h sel_q=%0d valid=%b expected %h/%0d/1", i, w_ou1, w_sel_q, w_valid, exp_w[i], i);
            end
        end
        w_en = 1'b0;
        tick();
        checks++;
        if (w_ou1 !== 8'h00 || w_valid !== 1'b0) begin
            errors++; $display("FAIL wide_hold: got ou1=%h valid=%b expected 00/0", w_ou1, w_valid);
        end
    endtask

    initial begin
        test_reset();
        test_comb_sweep();
        test_reset_release();
        test_back_to_back();
        test_hold();
        test_reset_vs_en();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
